ebpc_out_packer: RTL
====================

# ebpc_out_packer

Packs the narrow decoded stream of the EBPC decoder (one `DATA_W` value per beat, framed by `last`) into wide words of `PACK` values each. It sits directly downstream of `ebpc_decoder`, between the decoder and the memory/interconnect write port. It also emits a per-lane strobe and a per-frame value count. It must sustain one input beat per cycle under continuous output readiness.

## Interface
Parameters:
- `DATA_W`, 8, width of one decoded value; matches the decoder's `DATA_W`.
- `PACK`, 4, values per output word; must be ≥ 1.
- `LEN_W`, 24, width of the frame length counter.

Ports:
- `clk_i`  in  1  clock, single clock domain.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `data_i`  in  DATA_W  decoded value from the decoder's `data_o`.
- `last_i`  in  1  marks the final value of a frame.
- `vld_i`  in  1  input valid.
- `rdy_o`  out  1  input ready.
- `data_o`  out  PACK*DATA_W  packed word; lane k occupies bits `[k*DATA_W +: DATA_W]`, lane 0 in the LSBs.
- `strb_o`  out  PACK  bit k set iff lane k holds a written value.
- `last_o`  out  1  word contains the frame's final value.
- `frame_len_o`  out  LEN_W  number of values in the frame; meaningful only when `last_o` = 1, otherwise 0.
- `vld_o`  out  1  output valid.
- `rdy_i`  in  1  output ready.

## Operation
- Transfers occur on `vld && rdy` at the rising edge. Both sides follow the codebase handshake rules:
  - once `vld_o` is asserted, `data_o`, `strb_o`, `last_o` and `frame_len_o` stay stable until accepted;
  - `vld_o` never depends combinationally on `rdy_i`.
- The block holds one assembly register, plus lane index `idx` (0..PACK-1) and a frame counter `cnt` (LEN_W bits).
- FSM, two states:
  - **FILL** (reset state):
    - `rdy_o` = 1, `vld_o` = 0.
    - On input fire: write `data_i` into lane `idx`, set `strb[idx]`, `cnt <= cnt+1`.
    - If `idx == PACK-1` or `last_i`: go to HOLD, latch `last_o <= last_i`, and set `frame_len_o <= cnt+1` if `last_i`. Otherwise `idx <= idx+1`.
  - **HOLD**:
    - `vld_o` = 1, `rdy_o` = `rdy_i` (combinational pass-through).
    - On output fire without input fire: clear data/strb/last/frame_len to 0, `idx <= 0`, go to FILL.
    - On simultaneous output fire and input fire: the new value goes into lane 0 of a cleared word and `idx <= 1`. Apply the same completion test as FILL (stays in HOLD if `PACK == 1` or `last_i`).
- Unwritten lanes of a partial final word are 0 and their strobe bits are 0.
- `cnt` resets to 0 after each frame's last value is accepted. The count wraps modulo 2^LEN_W; there is no saturation or error flag.
- A frame ending exactly on `idx == PACK-1` produces a full word with `last_o` = 1. The block never emits an empty trailing word.
- `last_i` with `vld_i` = 0 is ignored.

## Timing
- Reset (asynchronous assert, synchronous release via the codebase reset driver): state FILL, `vld_o`=0, `data_o`=0, `strb_o`=0, `last_o`=0, `frame_len_o`=0, `idx`=0, `cnt`=0. After reset `rdy_o`=1.
- Latency: `vld_o` rises the cycle after the input beat that completes a word.
- Throughput: with `rdy_i` held at 1, `rdy_o` stays at 1 continuously and one word is emitted every PACK input beats. There are no bubbles, including across frame boundaries.
- Backpressure: while in HOLD with `rdy_i` = 0, `rdy_o` = 0. No input is accepted or lost.
- Reset mid-frame discards the partial word and the count. The next accepted value starts lane 0 of a new frame.

## Test plan
Configuration for all scenarios: DATA_W=8, PACK=4, LEN_W=24.
1. Bytes 0x01..0x08, `last_i` on 0x08, `rdy_i`=1 -> two words:
   - `0x04030201`, strb `0xF`, last 0;
   - `0x08070605`, strb `0xF`, last 1, `frame_len_o`=8.
2. Bytes 0x01..0x05, last on 0x05 -> `0x04030201`/`0xF`, then `0x00000005`/strb `0x1`/last 1/len 5. Immediately follow with the 3-byte frame 0xA0..0xA2 -> `0x00A2A1A0`/strb `0x7`/len 3. This checks the back-to-back frame boundary with no bubble.
3. Single byte 0xAA with last -> `0x000000AA`, strb `0x1`, last 1, len 1.
4. Backpressure: after the first word completes, hold `rdy_i`=0 for 10 cycles -> `rdy_o`=0 throughout and `data_o` stable. On release, the word is accepted in one cycle and the remaining input resumes with no loss or duplication.
5. Throughput: 4000 random bytes, `vld_i`=`rdy_i`=1, last on byte 4000 -> 1000 words, one per 4 cycles, `rdy_o` never low, final len 4000. Repeat with random 0-3 cycle waits on both sides and compare against the decoder's expected-response file packed by the reference model.
6. Reset mid-frame after 2 accepted bytes -> all outputs 0 during reset. The next frame of 4 bytes 0x11..0x14 with last -> `0x14131211`/`0xF`/len 4.

Source files
------------

// File: rtl/ebpc_out_packer.sv
// ebpc_out_packer: assembles the decoder's one-value-per-beat stream into
// PACK-lane words with per-lane strobes, a last flag and a per-frame count.
module ebpc_out_packer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PACK   = 4,
  parameter int unsigned LEN_W  = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [DATA_W-1:0]      data_i,
  input  logic                   last_i,
  input  logic                   vld_i,
  output logic                   rdy_o,
  output logic [PACK*DATA_W-1:0] data_o,
  output logic [PACK-1:0]        strb_o,
  output logic                   last_o,
  output logic [LEN_W-1:0]       frame_len_o,
  output logic                   vld_o,
  input  logic                   rdy_i
);

  localparam int unsigned IDX_W = (PACK > 1) ? $clog2(PACK) : 1;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [PACK*DATA_W-1:0] data_q,  data_d;
  logic [PACK-1:0]        strb_q,  strb_d;
  logic                   last_q,  last_d;
  logic [LEN_W-1:0]       len_q,   len_d;
  logic [IDX_W-1:0]       idx_q,   idx_d;
  logic [LEN_W-1:0]       cnt_q,   cnt_d;

  logic                   in_fire;
  logic                   out_fire;
  logic [IDX_W-1:0]       lane;

  // Handshake: the word is offered only in HOLD; input ready passes rdy_i
  // through while a word is held so a drained word can be refilled at once.
  always_comb begin
    vld_o    = (state_q == HOLD);
    rdy_o    = (state_q == FILL) | rdy_i;
    in_fire  = vld_i & rdy_o;
    out_fire = vld_o & rdy_i;
  end

  // Next-state: FILL and HOLD share one write path; a HOLD-state write always
  // lands in lane 0 of the word cleared by the simultaneous output fire.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    strb_d  = strb_q;
    last_d  = last_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lane    = (state_q == HOLD) ? '0 : idx_q;

    if (out_fire) begin
      state_d = FILL;
      data_d  = '0;
      strb_d  = '0;
      last_d  = 1'b0;
      len_d   = '0;
      idx_d   = '0;
    end

    if (in_fire) begin
      for (int unsigned k = 0; k < PACK; k++) begin
        if (lane == IDX_W'(k)) begin
          data_d[k*DATA_W +: DATA_W] = data_i;
          strb_d[k]                  = 1'b1;
        end
      end
      cnt_d = last_i ? '0 : cnt_q + LEN_W'(1);
      if ((lane == IDX_W'(PACK - 1)) || last_i) begin
        state_d = HOLD;
        last_d  = last_i;
        len_d   = last_i ? cnt_q + LEN_W'(1) : '0;
        idx_d   = '0;
      end else begin
        idx_d   = lane + IDX_W'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
      data_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      last_q  <= last_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs come straight from the assembly register.
  always_comb begin
    data_o      = data_q;
    strb_o      = strb_q;
    last_o      = last_q;
    frame_len_o = len_q;
  end

endmodule
